// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS sequencer FSM with memory-ready handshake and retire counter (optional ILLEGAL_TRAP_EN)
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             trap
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RFORMAT = 6'd0;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_ADDI    = 6'd8;
    localparam logic [5:0] OP_ANDI    = 6'd12;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_SW      = 6'd43;

    state_t cur, nxt;
    logic   is_andi;
    logic   retire;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            retired <= '0;
            is_andi <= 1'b0;
        end else begin
            cur <= nxt;
            if (retire)
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            // I_EXEC picks ADD vs AND from the opcode captured at decode
            if (cur == S_DECODE)
                is_andi <= (opcode == OP_ANDI);
        end
    end

    always_comb begin
        nxt           = cur;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        trap          = 1'b0;
        case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:     nxt = S_MEM_ADDR;
                    OP_RFORMAT:       nxt = S_R_EXEC;
                    OP_ADDI, OP_ANDI: nxt = S_I_EXEC;
                    OP_BEQ:           nxt = S_BRANCH;
                    OP_JAL:           nxt = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:          nxt = S_TRAP;
`else
                    default:          nxt = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    nxt    = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                retire    = 1'b1;
                nxt       = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = is_andi ? 2'b11 : 2'b00;
                nxt       = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                nxt           = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                retire     = 1'b1;
                nxt        = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: trap = 1'b1;
`endif
            default: nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control (optional ILLEGAL_TRAP_EN)
module tb_multicycle_control;
    localparam int CNT_W = 32;
    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3,
        MEM_READ = 4'd4, MEM_WB = 4'd5, MEM_WRITE = 4'd6, R_EXEC = 4'd7, R_WB = 4'd8,
        I_EXEC = 4'd9, I_WB = 4'd10, BRANCH = 4'd11, JUMP = 4'd12, TRAP = 4'd13;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, trap;
    logic [1:0]       pc_source, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .retired(retired), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        int         ret;
    } vec_t;

    typedef struct {
        int          step;
        logic [3:0]  st;
        logic [18:0] ctrl;
        logic [31:0] ret;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 0;

    // {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
    //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, trap}
    function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic mr);
        case (st)
            FETCH:     return {mr, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, mr, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0};
            DECODE:    return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0};
            MEM_ADDR:  return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0};
            MEM_READ:  return {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
            MEM_WB:    return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
            MEM_WRITE: return {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
            R_EXEC:    return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0};
            R_WB:      return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
            I_EXEC:    return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10,
                               (op == 6'd12) ? 2'b11 : 2'b00, 1'b0};
            I_WB:      return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
            BRANCH:    return {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0};
            JUMP:      return {1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
            TRAP:      return {18'd0, 1'b1};
            default:   return 19'd0;
        endcase
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st, input int ret);
        vec_t v;
        v.rst_n = r; v.op = op; v.mr = mr; v.st = st; v.ret = ret;
        vecs.push_back(v);
    endtask

    // Each vector: inputs driven during a cycle, plus the state/retired expected in that same cycle
    initial begin
        add(0, 0, 1, IDLE, 0);
        add(1, 0, 1, IDLE, 0);
        // R-format
        add(1, 0, 1, FETCH, 0);
        add(1, 0, 1, DECODE, 0);
        add(1, 0, 0, R_EXEC, 0);
        add(1, 0, 1, R_WB, 0);
        // LW with three wait cycles in MEM_READ
        add(1, 35, 1, FETCH, 1);
        add(1, 35, 1, DECODE, 1);
        add(1, 35, 1, MEM_ADDR, 1);
        add(1, 35, 0, MEM_READ, 1);
        add(1, 35, 0, MEM_READ, 1);
        add(1, 35, 0, MEM_READ, 1);
        add(1, 35, 1, MEM_READ, 1);
        add(1, 35, 1, MEM_WB, 1);
        // FETCH stall five cycles, then BEQ
        for (int i = 0; i < 5; i++) add(1, 4, 0, FETCH, 2);
        add(1, 4, 1, FETCH, 2);
        add(1, 4, 1, DECODE, 2);
        add(1, 4, 1, BRANCH, 2);
        // ANDI
        add(1, 12, 1, FETCH, 3);
        add(1, 12, 1, DECODE, 3);
        add(1, 12, 1, I_EXEC, 3);
        add(1, 12, 1, I_WB, 3);
        // JAL
        add(1, 3, 1, FETCH, 4);
        add(1, 3, 0, DECODE, 4);
        add(1, 3, 1, JUMP, 4);
        // SW interrupted by reset while waiting on memory
        add(1, 43, 1, FETCH, 5);
        add(1, 43, 1, DECODE, 5);
        add(1, 43, 0, MEM_ADDR, 5);
        add(0, 43, 0, MEM_WRITE, 5);
        add(1, 43, 1, IDLE, 0);
        // complete SW
        add(1, 43, 1, FETCH, 0);
        add(1, 43, 1, DECODE, 0);
        add(1, 43, 1, MEM_ADDR, 0);
        add(1, 43, 1, MEM_WRITE, 0);
        // ADDI
        add(1, 8, 1, FETCH, 1);
        add(1, 8, 1, DECODE, 1);
        add(1, 8, 1, I_EXEC, 1);
        add(1, 8, 1, I_WB, 1);
        // illegal opcode 63
        add(1, 63, 1, FETCH, 2);
        add(1, 63, 1, DECODE, 2);
`ifdef ILLEGAL_TRAP_EN
        add(1, 63, 1, TRAP, 2);
        add(1, 63, 0, TRAP, 2);
        add(1, 63, 1, TRAP, 2);
`else
        add(1, 63, 1, FETCH, 2);
        add(1, 63, 1, DECODE, 2);
        add(1, 63, 1, FETCH, 2);
`endif
    end

    initial begin
        rst_n = 1'b0;
        opcode = 6'd0;
        mem_ready = 1'b0;
        #0;
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            rst_n     = vecs[i].rst_n;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].mr;
            e.step = i;
            e.st   = vecs[i].st;
            e.ctrl = exp_ctrl(vecs[i].st, vecs[i].op, vecs[i].mr);
            e.ret  = vecs[i].ret;
            sb.push_back(e);
        end
        stim_done = 1;
    end

    initial begin : monitor
        int idle_cycles;
        idle_cycles = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                logic [18:0] got;
                e = sb.pop_front();
                got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, trap};
                n_cmp++;
                if (state !== e.st) begin
                    n_bad++;
                    $display("FAIL step%0d state: got %0d expected %0d", e.step, state, e.st);
                end
                n_cmp++;
                if (got !== e.ctrl) begin
                    n_bad++;
                    $display("FAIL step%0d ctrl: got %b expected %b", e.step, got, e.ctrl);
                end
                n_cmp++;
                if (retired !== e.ret) begin
                    n_bad++;
                    $display("FAIL step%0d retired: got %0d expected %0d", e.step, retired, e.ret);
                end
            end else if (stim_done) begin
                break;
            end else if (++idle_cycles > 1000) begin
                n_bad++;
                $display("FAIL timeout: stimulus never finished (queue %0d)", sb.size());
                break;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore FSM plus a memory-ready handshake.
- It drives PC/IR/register-file/ALU/memory enables each cycle for the opcode set RFORMAT(0), JAL(3), BEQ(4), ADDI(8), ANDI(12), LW(35) and SW(43).
- It sits between the shared instruction/data memory port and the datapath, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- pc_source  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load
- reg_dst  output  2  00 rt, 01 rd, 10 r31
- mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  output  1  register-file write
- alu_src_a  output  1  0 PC, 1 rs
- alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  output  2  00 add, 01 sub, 10 funct-decoded, 11 and
- state  output  4  current FSM state (debug)
- retired  output  CNT_W  completed-instruction count
- trap  output  1  illegal opcode (ILLEGAL_TRAP_EN only, else tied 0)

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset: rst_n=0 at posedge puts state in IDLE and clears retired. Mid-operation this deasserts all outputs (including mem_read/mem_write) from the next edge.
- Outputs not listed for a state are 0. All outputs are Moore, except FETCH's ir_write and pc_write, which equal mem_ready.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12, TRAP=13.
- IDLE: all outputs 0; goes to FETCH next cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. Holds while mem_ready=0; goes to DECODE on mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state:
  - LW/SW to MEM_ADDR
  - RFORMAT to R_EXEC
  - ADDI/ANDI to I_EXEC
  - BEQ to BRANCH
  - JAL to JUMP
  - other opcodes per Optional Feature
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ if LW, else MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Goes to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB (reg_write=1, reg_dst=01, mem_to_reg=00), then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for ADDI and 11 for ANDI. Goes to I_WB (reg_write=1, reg_dst=00, mem_to_reg=00), then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. Goes to FETCH.
- retired: +1 on every edge leaving MEM_WB, R_WB, I_WB, BRANCH or JUMP to FETCH, and leaving MEM_WRITE when mem_ready=1. Wraps at 2^CNT_W-1 to 0.
- Latency with mem_ready always 1: R/ADDI/ANDI/LW-less = 4 cycles; LW 5; SW 4; BEQ 3; JAL 3.
- mem_ready outside FETCH/MEM_READ/MEM_WRITE: ignored.
- Opcode is sampled only in DECODE and MEM_ADDR.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP drives trap=1 with all other outputs 0, and is held until reset. retired is not incremented.
- Undefined: an unknown opcode in DECODE goes to FETCH as a NOP, retired is not incremented, and the trap port is tied 0.

Test Plan:
- Reset then R-format: rst_n low 2 cycles, release, opcode=0, mem_ready=1 -> IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH; reg_write=1 and reg_dst=01 only in R_WB; retired=1.
- LW with memory wait: opcode=35, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_read=1, i_or_d=1; MEM_WB with mem_to_reg=01; retired increments once.
- FETCH stall: mem_ready=0 for 5 cycles -> ir_write=pc_write=0 throughout; both pulse 1 for exactly the mem_ready cycle.
- BEQ/ANDI/JAL sequence -> BRANCH has alu_op=01 and pc_write_cond=1; I_EXEC has alu_op=11; JUMP has reg_dst=10, mem_to_reg=10, pc_source=10; retired=3.
- Reset mid-SW: rst_n=0 while in MEM_WRITE with mem_ready=0 -> mem_write=0 after next edge, state=IDLE, retired=0.
- Opcode 63: with ILLEGAL_TRAP_EN -> state=13, trap=1 persistent; without -> returns to FETCH, retired unchanged.
